// File: rtl/sr_cmd_sequencer_pkg.sv
// rtl/sr_cmd_sequencer_pkg.sv - shared FSM states, op encodings and sizing helper for the S/R sequencer
package sr_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP} state_e;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;
  localparam int   DROP_W = 8;

  // One down-counter serves both the pulse and gap phases, so size it for the larger.
  function automatic int cnt_width(input int pulse_w, input int gap);
    int w;
    w = 1;
    if ($clog2(pulse_w) > w) w = $clog2(pulse_w);
    if ($clog2(gap) > w) w = $clog2(gap);
    return w;
  endfunction

endpackage

// File: rtl/sr_cmd_fifo.sv
// rtl/sr_cmd_fifo.sv - synchronous circular-buffer FIFO with full/empty flags
module sr_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  // The extra pointer MSB distinguishes a full buffer from an empty one.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign wr_ptr_d  = do_wr ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d  = do_rd ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/sr_cmd_sequencer.sv
// rtl/sr_cmd_sequencer.sv - buffers set/clear commands and replays them as non-overlapping s/r pulses
// SR_SEQ_COALESCE_EN: skip commands that would not change the shadowed flip-flop state.
module sr_cmd_sequencer
  import sr_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PULSE_W = 1,
  parameter int GAP     = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  input  logic              cmd_op_i,
  output logic              cmd_ready_o,
  output logic              s_o,
  output logic              r_o,
  output logic              busy_o,
  output logic              exp_q_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  localparam int             CW       = cnt_width(PULSE_W, GAP);
  localparam logic [CW-1:0]  PULSE_LD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0]  GAP_LD   = (GAP > 0) ? CW'(GAP - 1) : '0;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           s_q, s_d, r_q, r_d, exp_q_q, exp_q_d;
  logic           fifo_full, fifo_empty, fifo_op, pop, redundant;

  assign cmd_ready_o = !fifo_full && rst_ni;

  sr_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(1)) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (cmd_valid_i && cmd_ready_o),
    .wr_data_i (cmd_op_i),
    .rd_en_i   (pop),
    .rd_data_o (fifo_op),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

`ifdef SR_SEQ_COALESCE_EN
  logic [DROP_W-1:0] drop_q, drop_d;
  assign redundant  = (fifo_op == exp_q_q);
  assign drop_cnt_o = drop_q;
`else
  assign redundant  = 1'b0;
  assign drop_cnt_o = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    r_d     = r_q;
    exp_q_d = exp_q_q;
    pop     = 1'b0;
`ifdef SR_SEQ_COALESCE_EN
    drop_d  = drop_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (redundant) begin
`ifdef SR_SEQ_COALESCE_EN
            if (drop_q != '1) drop_d = drop_q + 1'b1;
`endif
          end else begin
            state_d = ST_PULSE;
            s_d     = (fifo_op == OP_SET);
            r_d     = (fifo_op == OP_CLR);
            cnt_d   = PULSE_LD;
          end
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          // s_q alone identifies the op being pulsed, so it becomes the new shadow value.
          exp_q_d = s_q;
          s_d     = 1'b0;
          r_d     = 1'b0;
          if (GAP == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            cnt_d   = GAP_LD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      exp_q_q <= 1'b0;
`ifdef SR_SEQ_COALESCE_EN
      drop_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      exp_q_q <= exp_q_d;
`ifdef SR_SEQ_COALESCE_EN
      drop_q  <= drop_d;
`endif
    end
  end

  assign s_o     = s_q;
  assign r_o     = r_q;
  assign exp_q_o = exp_q_q;
  assign busy_o  = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// tb/tb_sr_cmd_sequencer.sv - randomized self-checking bench for sr_cmd_sequencer (honours SR_SEQ_COALESCE_EN)
module tb_sr_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int PULSE_W = 2;
  localparam int GAP     = 1;
`ifdef SR_SEQ_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_ni, cmd_valid, cmd_op;
  logic       cmd_ready, s, r, busy, exp_q;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  sr_cmd_sequencer #(.DEPTH(DEPTH), .PULSE_W(PULSE_W), .GAP(GAP)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid),
    .cmd_op_i    (cmd_op),
    .cmd_ready_o (cmd_ready),
    .s_o         (s),
    .r_o         (r),
    .busy_o      (busy),
    .exp_q_o     (exp_q),
    .drop_cnt_o  (drop_cnt)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Timeline model: a popped command owns the output for PULSE_W edges and
  // blocks the next pop until PULSE_W+GAP+1 edges after its own pop.
  bit mq[$];
  int e_cnt   = 0;
  int free_at = 0;
  int pend_end, m_drop;
  bit pend, pend_op, m_exp;

  int s_rises, r_rises;
  int rise_at[$];
  bit rise_op[$];
  bit prev_s, prev_r;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pend    = 1'b0;
    free_at = 0;
    m_exp   = 1'b0;
    m_drop  = 0;
  endtask

  task automatic model_edge();
    int sz;
    bit op;
    e_cnt++;
    sz = mq.size();
    if (sz > 0 && e_cnt >= free_at) begin
      op = mq.pop_front();
      if (COAL && op == m_exp) begin
        if (m_drop < 255) m_drop++;
        free_at = e_cnt + 1;
      end else begin
        pend     = 1'b1;
        pend_op  = op;
        pend_end = e_cnt + PULSE_W;
        free_at  = e_cnt + PULSE_W + GAP + 1;
      end
    end
    if (pend && e_cnt == pend_end) begin
      m_exp = pend_op;
      pend  = 1'b0;
    end
    if (cmd_valid && sz < DEPTH) mq.push_back(cmd_op);
  endtask

  task automatic compare();
    bit eb;
    eb = (e_cnt < free_at - 1) || (mq.size() != 0);
    chk("s", 32'(s), 32'(pend && pend_op));
    chk("r", 32'(r), 32'(pend && !pend_op));
    chk("s_and_r", 32'(s & r), 32'd0);
    chk("busy", 32'(busy), 32'(eb));
    chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
    chk("exp_q", 32'(exp_q), 32'(m_exp));
    chk("drop_cnt", 32'(drop_cnt), COAL ? 32'(m_drop) : 32'd0);
    if (s === 1'b1 && !prev_s) begin s_rises++; rise_at.push_back(e_cnt); rise_op.push_back(1'b1); end
    if (r === 1'b1 && !prev_r) begin r_rises++; rise_at.push_back(e_cnt); rise_op.push_back(1'b0); end
    prev_s = (s === 1'b1);
    prev_r = (r === 1'b1);
  endtask

  task automatic clear_obs();
    prev_s = 1'b0; prev_r = 1'b0;
    s_rises = 0; r_rises = 0;
    rise_at.delete(); rise_op.delete();
  endtask

  task automatic step(input bit v, input bit o);
    cmd_valid = v;
    cmd_op    = o;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; cmd_valid = 1'b1; cmd_op = 1'b1;
    #1;
    chk("rst_async_s", 32'(s), 32'd0);
    chk("rst_async_r", 32'(r), 32'd0);
    chk("rst_async_ready", 32'(cmd_ready), 32'd0);
    model_reset();
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_r", 32'(r), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd0);
      chk("rst_exp_q", 32'(exp_q), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
    end
    rst_ni = 1'b1; cmd_valid = 1'b0;
    clear_obs();
  endtask

  initial begin
    bit ops[6];
    int acc, guard;
    bit ok, saw_low;

    rst_ni = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0;
    @(negedge clk);

    // reset with valid held high: nothing may be accepted
    do_reset();
    step(0, 0);
    chk("rst_nothing_accepted_busy", 32'(busy), 32'd0);

    // single set, accepted at edge N
    do_reset();
    step(1, 1);
    step(0, 0); chk("single_s_n1", 32'(s), 32'd1);
    step(0, 0); chk("single_s_n2", 32'(s), 32'd1); chk("single_exp_n2", 32'(exp_q), 32'd0);
    step(0, 0); chk("single_s_n3", 32'(s), 32'd0); chk("single_exp_n3", 32'(exp_q), 32'd1);
    step(0, 0);
    step(0, 0); chk("single_busy_n5", 32'(busy), 32'd0);

    // alternating set/clear/set/clear back to back
    do_reset();
    step(1, 1); step(1, 0); step(1, 1); step(1, 0);
    repeat (20) step(0, 0);
    chk("alt_pulses", 32'(rise_at.size()), 32'd4);
    for (int i = 1; i < rise_at.size(); i++) begin
      chk("alt_spacing", 32'(rise_at[i] - rise_at[i-1]), 32'd4);
      chk("alt_order", 32'(rise_op[i]), 32'(i % 2 == 0));
    end

    // clear, set, set from exp_q=0
    do_reset();
    step(1, 0); step(1, 1); step(1, 1);
    repeat (20) step(0, 0);
    chk("coal_s_pulses", 32'(s_rises), COAL ? 32'd1 : 32'd2);
    chk("coal_r_pulses", 32'(r_rises), COAL ? 32'd0 : 32'd1);
    chk("coal_drop", 32'(drop_cnt), COAL ? 32'd2 : 32'd0);

    // fill and overflow: hold each command until the FIFO takes it
    do_reset();
    foreach (ops[i]) ops[i] = 1'($urandom_range(0, 1));
    acc = 0; guard = 0; saw_low = 1'b0;
    while (acc < 6 && guard < 60) begin
      ok = (mq.size() < DEPTH);
      step(1, ops[acc]);
      if (ok) acc++;
      if (cmd_ready === 1'b0) saw_low = 1'b1;
      guard++;
    end
    chk("ovf_accepts", 32'(acc), 32'd6);
    chk("ovf_ready_low_seen", 32'(saw_low), 32'd1);
    repeat (40) step(0, 0);
    chk("ovf_all_issued", 32'(s_rises + r_rises + int'(drop_cnt)), 32'd6);

    // reset while s is high with two entries queued
    do_reset();
    step(1, 1); step(1, 0); step(1, 1);
    chk("mid_s_high", 32'(s), 32'd1);
    rst_ni = 1'b0; cmd_valid = 1'b0;
    #1;
    chk("mid_s_async_low", 32'(s), 32'd0);
    chk("mid_busy_async_low", 32'(busy), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    clear_obs();
    repeat (15) step(0, 0);
    chk("mid_no_pulses", 32'(s_rises + r_rises), 32'd0);
    chk("mid_idle", 32'(busy), 32'd0);

    // random traffic
    do_reset();
    repeat (400) step(bit'($urandom_range(0, 9) < 6), bit'($urandom_range(0, 1)));
    repeat (30) step(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
